// File: rtl/time_set_pkg.sv
// Shared types and display constants for the time-set controller.
package time_set_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_SET_SEC = 2'd3
  } state_e;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_HR   = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;
  localparam logic [1:0] FIELD_SEC  = 2'b11;

  localparam logic [7:0] LED_RUN     = 8'b0111_1111;
  localparam logic [7:0] LED_SET_HR  = 8'b1011_1111;
  localparam logic [7:0] LED_SET_MIN = 8'b1101_1111;
  localparam logic [7:0] LED_SET_SEC = 8'b1110_1111;

  localparam logic [7:0] BLANK_NONE = 8'h00;
  localparam logic [7:0] BLANK_HR   = 8'h03;
  localparam logic [7:0] BLANK_MIN  = 8'h18;
  localparam logic [7:0] BLANK_SEC  = 8'hC0;

  function automatic state_e next_mode(input state_e s);
    case (s)
      ST_RUN:     return ST_SET_HR;
      ST_SET_HR:  return ST_SET_MIN;
      ST_SET_MIN: return ST_SET_SEC;
      default:    return ST_RUN;
    endcase
  endfunction

  function automatic logic [1:0] field_of(input state_e s);
    case (s)
      ST_SET_HR:  return FIELD_HR;
      ST_SET_MIN: return FIELD_MIN;
      ST_SET_SEC: return FIELD_SEC;
      default:    return FIELD_NONE;
    endcase
  endfunction

  function automatic logic [7:0] led_of(input state_e s);
    case (s)
      ST_SET_HR:  return LED_SET_HR;
      ST_SET_MIN: return LED_SET_MIN;
      ST_SET_SEC: return LED_SET_SEC;
      default:    return LED_RUN;
    endcase
  endfunction

  function automatic logic [7:0] blank_of(input state_e s);
    case (s)
      ST_SET_HR:  return BLANK_HR;
      ST_SET_MIN: return BLANK_MIN;
      ST_SET_SEC: return BLANK_SEC;
      default:    return BLANK_NONE;
    endcase
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stable-level filter for one active-low push-button.
// press_o pulses for one cycle, the cycle after a debounced 1->0 is accepted.
module key_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, prev_q, press_q, armed_q;
  logic [CW-1:0] cnt_q;

  // A key must be seen released for a full filter window after reset before
  // presses count, so a button held through reset never fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      prev_q  <= level_q;
      press_q <= prev_q & ~level_q;
      if (!armed_q) begin
        if (!sync2_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          armed_q <= 1'b1;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Clock time-set controller: mode/up/down keys, blinking field, idle timeout.
// Define TIME_SET_AUTOREPEAT_EN to add hold-to-repeat on the up/down keys.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DB_CYCLES        = 500000,
  parameter int RPT_DELAY_CYCLES = 25000000,
  parameter int RPT_RATE_CYCLES  = 5000000,
  parameter int BLINK_CYCLES     = 12500000,
  parameter int TIMEOUT_TICKS    = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       tick_1hz,
  output logic       run_en,
  output logic [1:0] field_sel,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic [7:0] blank_mask,
  output logic [7:0] mode_led
);

  // Blink and repeat timers share one width sized for the longest interval.
  localparam int TMR_W  = $clog2(max3(BLINK_CYCLES, RPT_DELAY_CYCLES, RPT_RATE_CYCLES) + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TMR_W-1:0]  BLINK_LAST = TMR_W'(BLINK_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT_TICKS - 1);

  logic mode_level, mode_press, up_level, up_press, dn_level, dn_press;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk(clk), .rst(rst), .key_n_i(key_mode), .level_o(mode_level), .press_o(mode_press)
  );
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .key_n_i(key_up), .level_o(up_level), .press_o(up_press)
  );
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
    .clk(clk), .rst(rst), .key_n_i(key_down), .level_o(dn_level), .press_o(dn_press)
  );

  state_e              state_q, state_d;
  logic                run_en_q, inc_q, dec_q, inc_d, dec_d;
  logic [1:0]          field_q;
  logic [7:0]          blank_q, led_q;
  logic                blink_q, blink_d;
  logic [TMR_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                up_blk_q, up_blk_d, dn_blk_q, dn_blk_d;
  logic                entered;

  logic in_set, both_low, adj_ok, key_active, timeout;
  logic rpt_up, rpt_dn;

  assign in_set     = (state_q != ST_RUN);
  assign both_low   = ~up_level & ~dn_level;
  assign adj_ok     = in_set & ~mode_press & ~both_low;
  // A held key also counts as user activity, so auto-repeat never times out.
  assign key_active = mode_press | up_press | dn_press | ~mode_level | ~up_level | ~dn_level;
  assign timeout    = in_set & tick_1hz & ~key_active & (idle_q == IDLE_LAST);

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(RPT_DELAY_CYCLES - 1);
  localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(RPT_RATE_CYCLES - 1);

  logic [TMR_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_rate_q, rpt_rate_d;
  logic             up_held, dn_held;

  assign up_held = ~up_level & ~up_blk_q;
  assign dn_held = ~dn_level & ~dn_blk_q;

  always_comb begin
    rpt_cnt_d  = rpt_cnt_q;
    rpt_rate_d = rpt_rate_q;
    rpt_up     = 1'b0;
    rpt_dn     = 1'b0;
    if (!adj_ok || !(up_held || dn_held) || up_press || dn_press) begin
      rpt_cnt_d  = '0;
      rpt_rate_d = 1'b0;
    end else if (rpt_cnt_q == (rpt_rate_q ? RATE_LAST : DELAY_LAST)) begin
      rpt_cnt_d  = '0;
      rpt_rate_d = 1'b1;
      rpt_up     = up_held;
      rpt_dn     = dn_held;
    end else begin
      rpt_cnt_d = rpt_cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt_q  <= '0;
      rpt_rate_q <= 1'b0;
    end else begin
      rpt_cnt_q  <= rpt_cnt_d;
      rpt_rate_q <= rpt_rate_d;
    end
  end
`else
  assign rpt_up = 1'b0;
  assign rpt_dn = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, otherwise an
  // unassigned path infers a latch; combinational blocks use blocking '='.
  always_comb begin
    state_d = state_q;
    if (mode_press) begin
      state_d = next_mode(state_q);
    end else if (timeout) begin
      state_d = ST_RUN;
    end
    entered = (state_d != state_q);

    up_blk_d = up_blk_q & ~up_level;
    dn_blk_d = dn_blk_q & ~dn_level;
    if (mode_press) begin
      up_blk_d = ~up_level;
      dn_blk_d = ~dn_level;
    end

    inc_d = adj_ok & ((up_press & ~up_blk_q) | rpt_up);
    dec_d = adj_ok & ((dn_press & ~dn_blk_q) | rpt_dn);

    idle_d = idle_q;
    if (entered || key_active || !in_set) begin
      idle_d = '0;
    end else if (tick_1hz) begin
      idle_d = idle_q + IDLE_W'(1);
    end

    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    if (entered || inc_d || dec_d || state_d == ST_RUN) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_d     = ~blink_q;
      blink_cnt_d = '0;
    end else begin
      blink_cnt_d = blink_cnt_q + TMR_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      run_en_q    <= 1'b1;
      field_q     <= FIELD_NONE;
      led_q       <= LED_RUN;
      blank_q     <= BLANK_NONE;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      blink_q     <= 1'b1;
      blink_cnt_q <= '0;
      idle_q      <= '0;
      up_blk_q    <= 1'b0;
      dn_blk_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_en_q    <= (state_d == ST_RUN);
      field_q     <= field_of(state_d);
      led_q       <= led_of(state_d);
      blank_q     <= (state_d != ST_RUN && !blink_d) ? blank_of(state_d) : BLANK_NONE;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      idle_q      <= idle_d;
      up_blk_q    <= up_blk_d;
      dn_blk_q    <= dn_blk_d;
    end
  end

  assign run_en     = run_en_q;
  assign field_sel  = field_q;
  assign inc_pulse  = inc_q;
  assign dec_pulse  = dec_q;
  assign blank_mask = blank_q;
  assign mode_led   = led_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl with short timing parameters.
module tb_time_set_ctrl;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam int BL = 8;
  localparam int TO = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_mode = 1'b1, key_up = 1'b1, key_down = 1'b1, tick_1hz = 1'b0;
  logic       run_en, inc_pulse, dec_pulse;
  logic [1:0] field_sel;
  logic [7:0] blank_mask, mode_led;

  time_set_ctrl #(
    .DB_CYCLES(DB), .RPT_DELAY_CYCLES(RD), .RPT_RATE_CYCLES(RR),
    .BLINK_CYCLES(BL), .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk), .rst(rst), .key_mode(key_mode), .key_up(key_up), .key_down(key_down),
    .tick_1hz(tick_1hz), .run_en(run_en), .field_sel(field_sel), .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse), .blank_mask(blank_mask), .mode_led(mode_led)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int kind;  // 1 = inc, 2 = dec
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t obs_q[$];
  int     cyc = 0;
  int     checks = 0;
  int     failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    pulse_t p;
    if (!rst) begin
      if (inc_pulse) begin
        p.cyc = cyc; p.kind = 1; obs_q.push_back(p);
      end
      if (dec_pulse) begin
        p.cyc = cyc; p.kind = 2; obs_q.push_back(p);
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic m, input logic u, input logic d, input int n);
    key_mode = m; key_up = u; key_down = d;
    step(n);
    key_mode = 1'b1; key_up = 1'b1; key_down = 1'b1;
    step(12);
  endtask

  task automatic push_exp(input int ofs, input int kind);
    pulse_t p;
    p.cyc = ofs; p.kind = kind;
    exp_q.push_back(p);
  endtask

  // Expected pulse offsets for one key held n raw cycles in a set state.
  task automatic expect_hold(input int kind, input int n);
`ifdef TIME_SET_AUTOREPEAT_EN
    int o = 0;
    while (o <= n - 2) begin
      push_exp(o, kind);
      o = (o == 0) ? RD : o + RR;
    end
`else
    push_exp(0, kind);
`endif
  endtask

  task automatic score(input string tag);
    int n_exp = exp_q.size();
    int first;
    pulse_t e, o;
    check({tag, "_count"}, obs_q.size(), n_exp);
    if (obs_q.size() == n_exp && n_exp > 0) begin
      first = obs_q[0].cyc;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        check({tag, "_ofs"}, o.cyc - first, e.cyc);
        check({tag, "_kind"}, o.kind, e.kind);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_mode(input string tag, input int fs, input int led, input int run);
    @(negedge clk);
    check({tag, "_field"}, field_sel, fs);
    check({tag, "_led"}, mode_led, led);
    check({tag, "_run"}, run_en, run);
  endtask

  initial begin
    int entry;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_run_en", run_en, 1);
    check("rst_field", field_sel, 0);
    check("rst_led", mode_led, 8'h7F);
    check("rst_blank", blank_mask, 0);
    check("rst_inc", inc_pulse, 0);
    check("rst_dec", dec_pulse, 0);
    @(posedge clk); #1 rst = 1'b0;
    step(10);

    // Up in RUN is ignored.
    obs_q.delete();
    hold(1, 0, 1, 10);
    score("run_up");

    hold(0, 1, 1, 10);
    check_mode("set_hr", 1, 8'hBF, 0);

    obs_q.delete();
    expect_hold(1, 60);
    hold(1, 0, 1, 60);
    score("hr_hold");

    obs_q.delete();
    hold(1, 0, 0, 40);
    score("both_held");

    // Mode and up pressed together: advance, no adjust, no repeat.
    obs_q.delete();
    hold(0, 0, 1, 40);
    score("mode_up");
    check_mode("set_min", 2, 8'hDF, 0);

    obs_q.delete();
    hold(1, 0, 1, 3);
    score("glitch");
    push_exp(0, 1);
    hold(1, 0, 1, 10);
    score("min_up");
    push_exp(0, 2);
    hold(1, 1, 0, 10);
    score("min_down");

    // Enter SET_SEC and follow the blink pattern from the entry cycle.
    entry = -1;
    for (int i = 0; i < 40; i++) begin
      key_mode = (i < 10) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (entry < 0 && field_sel == 2'b11) entry = i;
      if (entry >= 0 && i - entry < 24)
        check("blink", blank_mask, (((i - entry) / BL) % 2 == 1) ? 8'hC0 : 8'h00);
    end
    check("sec_entry", (entry >= 0) ? 1 : 0, 1);
    check_mode("set_sec", 3, 8'hEF, 0);

    // Idle timeout: RUN one cycle after the third tick.
    for (int t = 0; t < TO; t++) begin
      step(4);
      @(negedge clk);
      tick_1hz = 1'b1;
      #1;
      if (t == TO - 1) check("to_before", run_en, 0);
      @(posedge clk);
      #1 tick_1hz = 1'b0;
    end
    check_mode("timeout", 0, 8'h7F, 1);
    check("timeout_blank", blank_mask, 0);

    // Reset while holding up: no pulse until the key is released and re-pressed.
    hold(0, 1, 1, 10);
    check_mode("rst_hold_hr", 1, 8'hBF, 0);
    key_up = 1'b0;
    step(15);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    check_mode("rst_mid", 0, 8'h7F, 1);
    obs_q.delete();
    step(10);
    key_mode = 1'b0;
    step(10);
    key_mode = 1'b1;
    step(12);
    check_mode("rst_re_hr", 1, 8'hBF, 0);
    step(20);
    score("rst_held");
    key_up = 1'b1;
    step(12);
    push_exp(0, 1);
    hold(1, 0, 1, 10);
    score("rst_repress");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DB_CYCLES, 500000, consecutive stable cycles before a key level is accepted.
REQ-002 Parameter RPT_DELAY_CYCLES, 25000000, hold time before auto-repeat starts.
REQ-003 Parameter RPT_RATE_CYCLES, 5000000, auto-repeat pulse period.
REQ-004 Parameter BLINK_CYCLES, 12500000, blink half-period.
REQ-005 Parameter TIMEOUT_TICKS, 30, idle 1 Hz ticks before a set mode returns to RUN.
REQ-006 clk  in  1  system clock; the block has one clock.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 key_mode, key_up, key_down  in  1 each  raw push-buttons, active-low, asynchronous.
REQ-009 tick_1hz  in  1  one-cycle pulse per second from the timebase.
REQ-010 run_en  out  1  high only in RUN; enables timekeeping count.
REQ-011 field_sel  out  2  00 none, 01 hours, 10 minutes, 11 seconds.
REQ-012 inc_pulse, dec_pulse  out  1 each  one-cycle adjust strobes to the selected field.
REQ-013 blank_mask  out  8  bit i high blanks display digit i (0 = leftmost).
REQ-014 mode_led  out  8  one-cold mode indicator.

Function
REQ-015 Each key SHALL pass a 2-FF synchronizer and a debouncer; a level is accepted after DB_CYCLES identical consecutive samples.
REQ-016 A press is an accepted 1->0 transition; it is recognized one cycle after acceptance.
REQ-017 FSM states: RUN, SET_HR, SET_MIN, SET_SEC; a mode press advances RUN->SET_HR->SET_MIN->SET_SEC->RUN.
REQ-018 field_sel SHALL be 00/01/10/11 in RUN/SET_HR/SET_MIN/SET_SEC; run_en = (state==RUN).
REQ-019 mode_led SHALL be 8'b01111111/10111111/11011111/11101111 for RUN/SET_HR/SET_MIN/SET_SEC.
REQ-020 In a set state, an up press SHALL assert inc_pulse for exactly one cycle on the recognition cycle; a down press likewise asserts dec_pulse.
REQ-021 In RUN, up/down presses SHALL produce no pulses.
REQ-022 If up and down are both accepted-low, no pulse SHALL be issued and the repeat counter SHALL be held at zero.
REQ-023 A mode press in the same cycle as an up/down press SHALL change state and suppress the adjust pulse; the held key produces no further pulses until released.
REQ-024 blink_phase SHALL toggle every BLINK_CYCLES; it is forced visible (1) with counter cleared on state entry and on every inc/dec pulse.
REQ-025 When blink_phase=0, blank_mask SHALL be 8'h03 in SET_HR, 8'h18 in SET_MIN, 8'hC0 in SET_SEC; otherwise 8'h00, and always 8'h00 in RUN.
REQ-026 In a set state, the idle counter SHALL increment on tick_1hz and clear on any press; reaching TIMEOUT_TICKS SHALL force RUN on the next cycle.
REQ-027 A mode press coincident with timeout SHALL take precedence (normal advance).
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 rst SHALL force state RUN, run_en=1, field_sel=00, inc/dec=0, blank_mask=0, mode_led=8'b01111111, all counters zero, synchronizers and debouncers to released (1).
REQ-030 rst asserted mid-hold or mid-repeat SHALL cancel the repeat; a key still held after reset produces no pulse until released and pressed again.

Configuration
REQ-031 Macro TIME_SET_AUTOREPEAT_EN defined: a held up/down key SHALL give a first pulse on press, a second after RPT_DELAY_CYCLES, then one every RPT_RATE_CYCLES until release.
REQ-032 Macro undefined: exactly one pulse per press; repeat counters not synthesized.

Structure
REQ-033 Package time_set_pkg SHALL hold the state enum, field_sel codes, mode_led constants and blank_mask constants.
REQ-034 Sub-module key_debounce (synchronizer plus DB_CYCLES filter, outputs level and press strobe) SHALL be instantiated three times.

Verification (DB_CYCLES=4, RPT_DELAY_CYCLES=20, RPT_RATE_CYCLES=5, BLINK_CYCLES=8, TIMEOUT_TICKS=3)
REQ-035 Reset, then key_mode low 10 cycles -> state SET_HR, field_sel=01, mode_led=8'b10111111, run_en=0.
REQ-036 SET_MIN, key_up low 3 cycles with glitch -> no inc_pulse; low 10 cycles -> exactly one inc_pulse.
REQ-037 SET_HR, key_up held 60 cycles (TIME_SET_AUTOREPEAT_EN) -> pulses at press, +20, +25, +30, ...; macro off -> one pulse.
REQ-038 SET_SEC, no keys, 3 tick_1hz pulses -> RUN one cycle after third tick; blank_mask toggles 8'hC0/8'h00 every 8 cycles before.
REQ-039 SET_HR, up and down held together 40 cycles -> zero pulses; rst mid-hold -> RUN, no pulse until re-press.
